// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage 20-bit pipeline: instruction layout,
// opcode constants and the controller state encoding.
package pipeline_pkg;

  typedef logic [19:0] instr_t;

  localparam int OP_HI  = 19;
  localparam int OP_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_J    = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } ctrl_state_e;

  function automatic logic [3:0] op_of(input instr_t i);
    return i[OP_HI:OP_LO];
  endfunction

  function automatic logic [3:0] rd_of(input instr_t i);
    return i[RD_HI:RD_LO];
  endfunction

  function automatic logic [3:0] rs1_of(input instr_t i);
    return i[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [3:0] rs2_of(input instr_t i);
    return i[RS2_HI:RS2_LO];
  endfunction

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Combinational hazard detection: load-use between ID/EX and IF/ID, and
// taken-branch/jump redirect from EX/MEM.
module hazard_detect
  import pipeline_pkg::*;
(
  input  instr_t id_instruction,
  input  instr_t ex_instruction,
  input  instr_t mem_instruction,
  input  logic   mem_alu_zero,
  output logic   load_use,
  output logic   redirect
);

  logic [3:0] id_op;
  logic [3:0] ex_op;
  logic [3:0] mem_op;
  logic       id_reads_rs1;
  logic       id_reads_rs2;
  logic       unused_fields;

  assign id_op  = op_of(id_instruction);
  assign ex_op  = op_of(ex_instruction);
  assign mem_op = op_of(mem_instruction);

  // NOP, J and HALT carry no register operands; LW reads only its base rs1.
  assign id_reads_rs1 = !(id_op inside {OP_NOP, OP_J, OP_HALT});
  assign id_reads_rs2 = !(id_op inside {OP_NOP, OP_LW, OP_J, OP_HALT});

  assign load_use = (ex_op == OP_LW) && (rd_of(ex_instruction) != 4'd0) &&
                    ((id_reads_rs1 && (rd_of(ex_instruction) == rs1_of(id_instruction))) ||
                     (id_reads_rs2 && (rd_of(ex_instruction) == rs2_of(id_instruction))));

  assign redirect = (mem_op == OP_J) || ((mem_op == OP_BEQ) && mem_alu_zero);

  assign unused_fields = ^{id_instruction[15:12], id_instruction[3:0],
                           ex_instruction[11:0], mem_instruction[15:0]};

endmodule

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller: PC/pipeline-register enables, flushes,
// load-use stalls, branch squashing and HALT drain, with a stall-cycle counter.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  instr_t      id_instruction,
  input  instr_t      ex_instruction,
  input  instr_t      mem_instruction,
  input  logic        mem_alu_zero,
  input  logic [19:0] mem_alu_result,
  output logic        pc_write,
  output logic        pc_sel,
  output logic [19:0] pc_target,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [15:0] stall_total
);

  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);

  ctrl_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             load_use, redirect;
  logic             stall_inc;

  hazard_detect u_hazard (
    .id_instruction  (id_instruction),
    .ex_instruction  (ex_instruction),
    .mem_instruction (mem_instruction),
    .mem_alu_zero    (mem_alu_zero),
    .load_use        (load_use),
    .redirect        (redirect)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    pc_target    = '0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          pc_sel       = 1'b1;
          pc_target    = mem_alu_result;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_n = ST_STALL;
            cnt_n   = STALL_INIT;
          end
        end else if (op_of(mem_instruction) == OP_HALT) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          state_n     = ST_DRAIN;
          cnt_n       = DRAIN_INIT;
        end
      end
      ST_STALL: begin
        // A squashing redirect makes the remaining bubbles pointless.
        if (redirect) begin
          pc_sel       = 1'b1;
          pc_target    = mem_alu_result;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          state_n      = ST_RUN;
          cnt_n        = '0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          cnt_n       = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end
      end
      ST_DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (cnt == '0) state_n = ST_HALTED;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      ST_HALTED: begin
        halted      = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = '0;
      end
    endcase
  end

  assign stall_inc = !pc_write && (state != ST_HALTED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      stall_total <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_inc && (stall_total != 16'hFFFF)) stall_total <= stall_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboarded bench for pipeline_control: one instance with default
// parameters and one with STALL_CYCLES=3 sharing the same stimulus.
module tb_pipeline_control;
  import pipeline_pkg::*;

  localparam int W = 43;

  // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  localparam logic [6:0] C_RUN     = 7'b1010000;
  localparam logic [6:0] C_STALL   = 7'b0000100;
  localparam logic [6:0] C_REDIR   = 7'b1111110;
  localparam logic [6:0] C_HALTDET = 7'b0011000;
  localparam logic [6:0] C_DRAIN   = 7'b0001100;
  localparam logic [6:0] C_HALTED  = 7'b0000001;

  localparam instr_t NOP     = 20'h00000;
  localparam instr_t ADD_R3  = 20'h51300;
  localparam instr_t SW_R3   = 20'h20130;
  localparam instr_t ADD_R0  = 20'h51000;
  localparam instr_t J_R3    = 20'h40330;
  localparam instr_t LW_RS23 = 20'h11030;
  localparam instr_t LW_RD3  = 20'h13000;
  localparam instr_t LW_RD0  = 20'h10000;
  localparam instr_t BEQ     = 20'h30000;
  localparam instr_t JMP     = 20'h40000;
  localparam instr_t HALT    = 20'hF0000;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_t      id_instruction, ex_instruction, mem_instruction;
  logic        mem_alu_zero;
  logic [19:0] mem_alu_result;

  logic        a_pc_write, a_pc_sel, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_halted;
  logic [19:0] a_pc_target;
  logic [15:0] a_stall_total;
  logic        b_pc_write, b_pc_sel, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_halted;
  logic [19:0] b_pc_target;
  logic [15:0] b_stall_total;

  pipeline_control dut_a (
    .clock(clock), .reset(reset),
    .id_instruction(id_instruction), .ex_instruction(ex_instruction),
    .mem_instruction(mem_instruction), .mem_alu_zero(mem_alu_zero),
    .mem_alu_result(mem_alu_result),
    .pc_write(a_pc_write), .pc_sel(a_pc_sel), .pc_target(a_pc_target),
    .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
    .halted(a_halted), .stall_total(a_stall_total)
  );

  pipeline_control #(.STALL_CYCLES(3), .DRAIN_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset),
    .id_instruction(id_instruction), .ex_instruction(ex_instruction),
    .mem_instruction(mem_instruction), .mem_alu_zero(mem_alu_zero),
    .mem_alu_result(mem_alu_result),
    .pc_write(b_pc_write), .pc_sel(b_pc_sel), .pc_target(b_pc_target),
    .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
    .halted(b_halted), .stall_total(b_stall_total)
  );

  logic [6:0] ctrl_a, ctrl_b;
  assign ctrl_a = {a_pc_write, a_pc_sel, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_halted};
  assign ctrl_b = {b_pc_write, b_pc_sel, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_halted};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_total;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input instr_t id_i, input instr_t ex_i, input instr_t mem_i,
                       input logic z, input logic [19:0] res);
    id_instruction  = id_i;
    ex_instruction  = ex_i;
    mem_instruction = mem_i;
    mem_alu_zero    = z;
    mem_alu_result  = res;
  endtask

  // One cycle: drive after the edge, expect Mealy outputs before the next edge.
  task automatic step(input string tag, input bit sel, input instr_t id_i, input instr_t ex_i,
                      input instr_t mem_i, input logic z, input logic [19:0] res,
                      input logic [6:0] ec, input logic [19:0] et);
    logic [W-1:0] got, exp;
    @(posedge clock);
    #1;
    drive(id_i, ex_i, mem_i, z, res);
    exp_q.push_back({ec, et, exp_total});
    #3;
    got = sel ? {ctrl_b, b_pc_target, b_stall_total} : {ctrl_a, a_pc_target, a_stall_total};
    exp = exp_q.pop_front();
    check({tag, "/ctrl"},   got[42:36], exp[42:36]);
    check({tag, "/target"}, got[35:16], exp[35:16]);
    check({tag, "/total"},  got[15:0],  exp[15:0]);
    if (!ec[6] && !ec[0] && exp_total != 16'hFFFF) exp_total = exp_total + 16'd1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    drive(NOP, NOP, NOP, 1'b0, 20'h0);
    reset = 1'b1;
    exp_total = 16'd0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    drive(NOP, NOP, NOP, 1'b0, 20'h0);
    exp_total = 16'd0;
    #2;
    check("reset/ctrl_a", ctrl_a, C_RUN);
    check("reset/ctrl_b", ctrl_b, C_RUN);
    check("reset/target", a_pc_target, 20'h0);
    check("reset/total",  a_stall_total, 16'h0);
    #2;
    reset = 1'b0;

    // load-use and false-stall cases, default parameters
    do_reset();
    step("lu_rs1",      0, ADD_R3,  LW_RD3, NOP, 1'b0, 20'h0, C_STALL, 20'h0);
    step("lu_bubble",   0, ADD_R3,  NOP,    NOP, 1'b0, 20'h0, C_RUN,   20'h0);
    step("lu_rs2",      0, SW_R3,   LW_RD3, NOP, 1'b0, 20'h0, C_STALL, 20'h0);
    step("lu_rs2_done", 0, SW_R3,   NOP,    NOP, 1'b0, 20'h0, C_RUN,   20'h0);
    step("rd0",         0, ADD_R0,  LW_RD0, NOP, 1'b0, 20'h0, C_RUN,   20'h0);
    step("id_j",        0, J_R3,    LW_RD3, NOP, 1'b0, 20'h0, C_RUN,   20'h0);
    step("lw_no_rs2",   0, LW_RS23, LW_RD3, NOP, 1'b0, 20'h0, C_RUN,   20'h0);

    // redirects
    step("beq_taken",   0, NOP,    NOP,    BEQ, 1'b1, 20'h00040, C_REDIR, 20'h00040);
    step("beq_not",     0, NOP,    NOP,    BEQ, 1'b0, 20'h00040, C_RUN,   20'h0);
    step("j_over_lu",   0, ADD_R3, LW_RD3, JMP, 1'b0, 20'h00123, C_REDIR, 20'h00123);
    step("after_j",     0, NOP,    NOP,    NOP, 1'b0, 20'h0,     C_RUN,   20'h0);

    // STALL_CYCLES=3: redirect on the 2nd STALL cycle, then a full stall
    do_reset();
    step("s3_lu",       1, ADD_R3, LW_RD3, NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    step("s3_st1",      1, ADD_R3, NOP,    NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    step("s3_redir",    1, ADD_R3, NOP,    JMP, 1'b0, 20'h00ABC, C_REDIR, 20'h00ABC);
    step("s3_run",      1, NOP,    NOP,    NOP, 1'b0, 20'h0,     C_RUN,   20'h0);
    step("s3_full_lu",  1, ADD_R3, LW_RD3, NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    step("s3_full_1",   1, ADD_R3, NOP,    NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    step("s3_full_2",   1, ADD_R3, NOP,    NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    step("s3_full_run", 1, ADD_R3, NOP,    NOP, 1'b0, 20'h0,     C_RUN,   20'h0);

    // reset in the middle of a stall
    step("s3_lu2",      1, ADD_R3, LW_RD3, NOP, 1'b0, 20'h0,     C_STALL, 20'h0);
    @(posedge clock);
    #2;
    drive(ADD_R3, NOP, NOP, 1'b0, 20'h0);
    reset = 1'b1;
    #1;
    check("s3_rst/ctrl",  ctrl_b, C_RUN);
    check("s3_rst/total", b_stall_total, 16'h0);
    #1;
    reset = 1'b0;
    exp_total = 16'd0;
    step("s3_post_rst", 1, ADD_R3, NOP, NOP, 1'b0, 20'h0, C_RUN, 20'h0);

    // HALT drain, DRAIN_CYCLES=2
    do_reset();
    step("halt_det", 0, NOP, NOP, HALT, 1'b0, 20'h0, C_HALTDET, 20'h0);
    step("drain_1",  0, NOP, NOP, NOP,  1'b0, 20'h0, C_DRAIN,   20'h0);
    step("drain_2",  0, NOP, NOP, NOP,  1'b0, 20'h0, C_DRAIN,   20'h0);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("halted_%0d", i), 0, ADD_R3, LW_RD3, JMP, 1'b1, 20'h00055, C_HALTED, 20'h0);
    end
    @(posedge clock);
    #2;
    drive(NOP, NOP, NOP, 1'b0, 20'h0);
    reset = 1'b1;
    #1;
    check("halt_rst/halted",   a_halted, 1'b0);
    check("halt_rst/pc_write", a_pc_write, 1'b1);
    #1;
    reset = 1'b0;

    // counter saturation: a held load-use keeps the default instance stalling
    do_reset();
    @(posedge clock);
    #1;
    drive(ADD_R3, LW_RD3, NOP, 1'b0, 20'h0);
    repeat (70000) @(posedge clock);
    #1;
    check("sat/total",    a_stall_total, 16'hFFFF);
    check("sat/pc_write", a_pc_write, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
